dec_to_bcd_keypad: RTL
======================

# dec_to_bcd_keypad

Sequential decimal-to-BCD encoder for a ten-key decimal keypad, the input-side counterpart of the BCD-to-decimal decoder used in the display path. It synchronizes the one-hot key lines, rejects bounce and multi-key presses, and encodes each accepted press into a 4-bit BCD code. It also shifts each accepted code into a multi-digit BCD entry register that feeds downstream display and arithmetic blocks.

## Interface
- `DIGITS`, default 4: number of BCD digits held in the entry register (range 1..8).
- `DB_CYCLES`, default 4: number of consecutive stable cycles required before a press is accepted (range 1..255). Used only when `KEYPAD_DEBOUNCE_EN` is defined.
- `clk`  in  1  clock. All logic triggers on the rising edge.
- `rst`  in  1  reset, synchronous and active-high. Highest priority.
- `key_in`  in  10  raw key lines; bit n high means digit n is pressed. Asynchronous to `clk`.
- `clr`  in  1  synchronous clear of the entry register.
- `bcd`  out  4  BCD code of the most recently accepted key.
- `bcd_valid`  out  1  single-cycle pulse marking a newly accepted key.
- `multi_err`  out  1  single-cycle pulse when two or more keys are seen from IDLE.
- `digits`  out  4*DIGITS  entry register. The newest digit is in nibble [3:0].
- `count`  out  clog2(DIGITS+1)  number of digits entered, saturating at `DIGITS`.
- `full`  out  1  high while `count == DIGITS`.

## Operation
- Input path: 2-flop synchronizer on `key_in`. Its output is `key_s`. All FSM decisions use `key_s` only.
- `key_s` is classified each cycle as one of:
  - none: all zeros.
  - single: exactly one bit set; the candidate code is the index of that bit (0..9).
  - multi: two or more bits set.
- FSM states and transitions:
  - IDLE:
    - none → stay in IDLE.
    - single → latch the candidate one-hot value and its code, clear the debounce counter, go to DEBOUNCE.
    - multi → pulse `multi_err` for 1 cycle, go to HELD.
  - DEBOUNCE:
    - If `key_s` differs from the latched one-hot value, go to IDLE. Nothing is emitted and no error is flagged.
    - Otherwise increment the counter. When the counter reaches `DB_CYCLES-1`, go to CAPTURE.
  - CAPTURE: 1 cycle, `bcd_valid` = 1, then go to HELD.
  - HELD: stay until `key_s` is none, then go to IDLE. A key held down is therefore accepted exactly once.
- On the edge that enters CAPTURE, the following update together:
  - `bcd` ← code.
  - `digits` ← {`digits`[4*DIGITS-5:0], code}. The oldest digit is dropped.
  - `count` ← min(`count`+1, DIGITS).
- `clr` with no capture on the same edge: `digits` ← 0, `count` ← 0. The FSM and `bcd` are unaffected.
- `clr` and a capture on the same edge: the clear is applied first, then the shift. Result: `digits` = {0…, code}, `count` = 1.
- Full register: further captures still shift in. `count` stays at `DIGITS` and `full` stays 1.
- `bcd` always holds a value in 0..9. Codes 10..15 are never produced.

## Timing
- Reset values: `bcd` = 0, `bcd_valid` = 0, `multi_err` = 0, `digits` = 0, `count` = 0, `full` = 0. Synchronizer flops = 0, FSM = IDLE, debounce counter = 0.
- `rst` asserted mid-operation (including during DEBOUNCE or CAPTURE): the pending press is discarded. After `rst` is released, a key that is still held is treated as a new press.
- Latency, counting edge 1 as the first rising edge that samples a stable `key_in`:
  - With debounce: `bcd_valid` is high in the cycle after edge DB_CYCLES+3. With `DB_CYCLES` = 4, that is after edge 7.
  - Without debounce: `bcd_valid` is high after edge 3.
- `multi_err` is high in the cycle after edge 3 when the multi pattern is stable.
- `full` is combinational from `count`, so it is valid in the same cycle as `count`.
- Minimum spacing between two `bcd_valid` pulses: one cycle in HELD plus one cycle in IDLE with none, then the press latency again.

## Configuration
- `KEYPAD_DEBOUNCE_EN` defined: the DEBOUNCE state and counter exist, as described above.
- `KEYPAD_DEBOUNCE_EN` undefined:
  - The DEBOUNCE state and counter are removed and `DB_CYCLES` is ignored.
  - IDLE with single goes directly to CAPTURE.
  - All other behaviour is identical.

## Test plan
- Reset: `rst` = 1 for 2 cycles with `key_in` = 10'h010 → all outputs 0 and no `bcd_valid`. After release, the held key 4 is accepted with the normal latency.
- Single press, debounce on, `DB_CYCLES` = 4: `key_in` = 10'h080 held for 12 cycles, then 0 → exactly one `bcd_valid` pulse after edge 7, `bcd` = 7, `digits` = 16'h0007, `count` = 1.
- Sequence 1, 9, 8, 4, 5, each with a press then release → `full` = 1 after the 4th digit with `digits` = 16'h1984. After the 5th: `digits` = 16'h9845, `count` = 4.
- Bounce: key 3 on for 2 cycles, off for 1 cycle, on for 2 cycles, then stable → no pulse during the bounce. Exactly one `bcd_valid` with `bcd` = 3 once the key is stable for `DB_CYCLES`.
- Multi-key: `key_in` = 10'b0000100010 → one `multi_err` pulse and no `bcd_valid`. After release, re-pressing key 5 alone gives `bcd` = 5.
- Clear collision: `digits` = 16'h1234, `count` = 4, with `clr` asserted on the CAPTURE-entry edge of key 6 → `digits` = 16'h0006, `count` = 1, `full` = 0.

Source files
------------

// File: rtl/dec_to_bcd_keypad_if.sv
// Keypad encoder bus: raw key lines and clear in, accepted BCD code and entry register out.
// master drives the keypad side, slave is the encoder.
interface dec_to_bcd_keypad_if #(
   parameter int DIGITS = 4
) ();
   logic [9:0]                     key_in;
   logic                           clr;
   logic [3:0]                     bcd;
   logic                           bcd_valid;
   logic                           multi_err;
   logic [4*DIGITS-1:0]            digits;
   logic [$clog2(DIGITS+1)-1:0]    count;
   logic                           full;

   modport master (
      output key_in, clr,
      input  bcd, bcd_valid, multi_err, digits, count, full
   );

   modport slave (
      input  key_in, clr,
      output bcd, bcd_valid, multi_err, digits, count, full
   );
endinterface

// File: rtl/dec_to_bcd_keypad.sv
// Ten-key keypad to BCD encoder with multi-key rejection and a shifting BCD entry register.
// Optional debounce stage enabled by defining KEYPAD_DEBOUNCE_EN.
module dec_to_bcd_keypad #(
   parameter int DIGITS    = 4,
   parameter int DB_CYCLES = 4
) (
   input logic                clk,
   input logic                rst,
   dec_to_bcd_keypad_if.slave bus
);
   localparam int CW = $clog2(DIGITS + 1);
   localparam int DW = 4 * DIGITS;

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("dec_to_bcd_keypad: DIGITS must be in 1..8");
   end
   if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db_cycles
      $error("dec_to_bcd_keypad: DB_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
`ifdef KEYPAD_DEBOUNCE_EN
      S_DEBOUNCE = 2'd1,
`endif
      S_CAPTURE  = 2'd2,
      S_HELD     = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [9:0]      key_meta_q, key_meta_d;
   logic [9:0]      key_s_q, key_s_d;
   logic [3:0]      bcd_q, bcd_d;
   logic            multi_err_q, multi_err_d;
   logic [DW-1:0]   digits_q, digits_d;
   logic [CW-1:0]   count_q, count_d;
`ifdef KEYPAD_DEBOUNCE_EN
   logic [9:0]      key_lat_q, key_lat_d;
   logic [3:0]      code_lat_q, code_lat_d;
   logic [7:0]      db_cnt_q, db_cnt_d;
`endif

   logic            is_none, is_single, is_multi;
   logic [3:0]      cand_code;
   logic            capture;
   logic [3:0]      cap_code;
   logic [DW-1:0]   digits_base, code_ext;
   logic [CW-1:0]   count_base;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      key_meta_d = bus.key_in;
      key_s_d    = key_meta_q;
      is_none    = (key_s_q == '0);
      is_single  = !is_none && ((key_s_q & (key_s_q - 10'd1)) == '0);
      is_multi   = !is_none && !is_single;
      cand_code  = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (key_s_q[i]) cand_code = 4'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      multi_err_d = 1'b0;
      capture     = 1'b0;
      cap_code    = cand_code;
`ifdef KEYPAD_DEBOUNCE_EN
      key_lat_d   = key_lat_q;
      code_lat_d  = code_lat_q;
      db_cnt_d    = db_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (is_single) begin
`ifdef KEYPAD_DEBOUNCE_EN
               key_lat_d  = key_s_q;
               code_lat_d = cand_code;
               db_cnt_d   = 8'd0;
               state_d    = S_DEBOUNCE;
`else
               capture    = 1'b1;
               state_d    = S_CAPTURE;
`endif
            end else if (is_multi) begin
               multi_err_d = 1'b1;
               state_d     = S_HELD;
            end
         end
`ifdef KEYPAD_DEBOUNCE_EN
         S_DEBOUNCE: begin
            // Any change of the lines, including release or a second key, silently abandons the press.
            if (key_s_q != key_lat_q) begin
               state_d = S_IDLE;
            end else if (db_cnt_q == 8'(DB_CYCLES - 1)) begin
               capture  = 1'b1;
               cap_code = code_lat_q;
               state_d  = S_CAPTURE;
            end else begin
               db_cnt_d = db_cnt_q + 8'd1;
            end
         end
`endif
         S_CAPTURE: state_d = S_HELD;
         S_HELD: begin
            if (is_none) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Clear is applied before the shift so a same-edge capture lands in an emptied register.
   always_comb begin
      digits_base = bus.clr ? '0 : digits_q;
      count_base  = bus.clr ? '0 : count_q;
      code_ext    = '0;
      code_ext[3:0] = cap_code;
      digits_d    = digits_base;
      count_d     = count_base;
      bcd_d       = bcd_q;
      if (capture) begin
         bcd_d    = cap_code;
         digits_d = (digits_base << 4) | code_ext;
         count_d  = (count_base == CW'(DIGITS)) ? count_base : count_base + CW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         key_meta_q  <= '0;
         key_s_q     <= '0;
         bcd_q       <= '0;
         multi_err_q <= 1'b0;
         digits_q    <= '0;
         count_q     <= '0;
`ifdef KEYPAD_DEBOUNCE_EN
         key_lat_q   <= '0;
         code_lat_q  <= '0;
         db_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         key_meta_q  <= key_meta_d;
         key_s_q     <= key_s_d;
         bcd_q       <= bcd_d;
         multi_err_q <= multi_err_d;
         digits_q    <= digits_d;
         count_q     <= count_d;
`ifdef KEYPAD_DEBOUNCE_EN
         key_lat_q   <= key_lat_d;
         code_lat_q  <= code_lat_d;
         db_cnt_q    <= db_cnt_d;
`endif
      end
   end

   assign bus.bcd       = bcd_q;
   assign bus.bcd_valid = (state_q == S_CAPTURE);
   assign bus.multi_err = multi_err_q;
   assign bus.digits    = digits_q;
   assign bus.count     = count_q;
   assign bus.full      = (count_q == CW'(DIGITS));
endmodule
